// File: rtl/goroutine_host_loader.sv
// Host-side sequencer for the goroutines core: streams words into s0/s1,
// kicks a run, waits for the core to go idle and returns the a/b result pair.
module goroutine_host_loader #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 16,
    parameter int ARM_CYC = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] count,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [1:0]        in_dst,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] s0_address,
    output logic              s0_we,
    output logic              s0_oe,
    output logic [WIDTH-1:0]  s0_din,
    output logic [ADDR_W-1:0] s1_address,
    output logic              s1_we,
    output logic              s1_oe,
    output logic [WIDTH-1:0]  s1_din,
    output logic              core_req,
    input  logic              core_busy,
    input  logic [WIDTH-1:0]  a_out,
    input  logic [WIDTH-1:0]  b_out,
    output logic [WIDTH-1:0]  res_a,
    output logic [WIDTH-1:0]  res_b,
    output logic              res_valid,
    output logic              busy,
    output logic              err_count,
    output logic              err_timeout
);
    typedef enum logic [2:0] {IDLE, LOAD, KICK, ARM, WAIT} state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ARM_LAST  = ADDR_W'(ARM_CYC - 1);
    localparam logic [ADDR_W-1:0] WAIT_LAST = ADDR_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d, idx_q, idx_d, cnt_q, cnt_d;
    logic              last_word;

    logic [ADDR_W-1:0] s0_address_q, s0_address_d, s1_address_q, s1_address_d;
    logic [WIDTH-1:0]  s0_din_q, s0_din_d, s1_din_q, s1_din_d;
    logic [WIDTH-1:0]  res_a_q, res_a_d, res_b_q, res_b_d;
    logic              s0_we_q, s0_we_d, s1_we_q, s1_we_d, s0_oe_q, s0_oe_d, s1_oe_q, s1_oe_d;
    logic              in_ready_q, in_ready_d, core_req_q, core_req_d;
    logic              res_valid_q, res_valid_d, busy_q, busy_d;
    logic              err_count_q, err_count_d, err_timeout_q, err_timeout_d;

    assign last_word = (idx_q == count_q - ONE_A);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            count_q       <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            s0_address_q  <= '0;
            s1_address_q  <= '0;
            s0_din_q      <= '0;
            s1_din_q      <= '0;
            s0_we_q       <= 1'b0;
            s1_we_q       <= 1'b0;
            s0_oe_q       <= 1'b1;
            s1_oe_q       <= 1'b1;
            in_ready_q    <= 1'b0;
            core_req_q    <= 1'b0;
            res_a_q       <= '0;
            res_b_q       <= '0;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            err_count_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            s0_address_q  <= s0_address_d;
            s1_address_q  <= s1_address_d;
            s0_din_q      <= s0_din_d;
            s1_din_q      <= s1_din_d;
            s0_we_q       <= s0_we_d;
            s1_we_q       <= s1_we_d;
            s0_oe_q       <= s0_oe_d;
            s1_oe_q       <= s1_oe_d;
            in_ready_q    <= in_ready_d;
            core_req_q    <= core_req_d;
            res_a_q       <= res_a_d;
            res_b_q       <= res_b_d;
            res_valid_q   <= res_valid_d;
            busy_q        <= busy_d;
            err_count_q   <= err_count_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // cnt_q is shared: ARM settle cycles, then WAIT timeout cycles
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                if (count == '0) begin
                    state_d = KICK;
                end else if (count <= DEPTH_A) begin
                    state_d = LOAD;
                    count_d = count;
                    idx_d   = '0;
                end
            end
            LOAD: if (in_valid && in_ready_q) begin
                idx_d = idx_q + ONE_A;
                if (last_word) state_d = KICK;
            end
            KICK: begin
                state_d = ARM;
                cnt_d   = '0;
            end
            ARM: if (core_busy) begin
                state_d = WAIT;
                cnt_d   = '0;
            end else if (cnt_q == ARM_LAST) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + ONE_A;
            end
            WAIT: if (!core_busy || cnt_q == WAIT_LAST) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + ONE_A;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s0_address_d  = '0;
        s1_address_d  = '0;
        s0_din_d      = '0;
        s1_din_d      = '0;
        s0_we_d       = 1'b0;
        s1_we_d       = 1'b0;
        s0_oe_d       = 1'b1;
        s1_oe_d       = 1'b1;
        in_ready_d    = in_ready_q;
        core_req_d    = 1'b0;
        res_a_d       = res_a_q;
        res_b_d       = res_b_q;
        res_valid_d   = 1'b0;
        busy_d        = busy_q;
        err_count_d   = 1'b0;
        err_timeout_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (count > DEPTH_A) begin
                    err_count_d = 1'b1;
                end else begin
                    busy_d     = 1'b1;
                    in_ready_d = (count != '0);
                end
            end
            LOAD: if (in_valid && in_ready_q) begin
                if (in_dst[0]) begin
                    s0_we_d      = 1'b1;
                    s0_address_d = idx_q;
                    s0_din_d     = in_data;
                end
                if (in_dst[1]) begin
                    s1_we_d      = 1'b1;
                    s1_address_d = idx_q;
                    s1_din_d     = in_data;
                end
                if (last_word) in_ready_d = 1'b0;
            end
            KICK: core_req_d = 1'b1;
            ARM: if (!core_busy && cnt_q == ARM_LAST) begin
                res_a_d     = a_out;
                res_b_d     = b_out;
                res_valid_d = 1'b1;
                busy_d      = 1'b0;
            end
            WAIT: if (!core_busy) begin
                res_a_d     = a_out;
                res_b_d     = b_out;
                res_valid_d = 1'b1;
                busy_d      = 1'b0;
            end else if (cnt_q == WAIT_LAST) begin
                err_timeout_d = 1'b1;
                busy_d        = 1'b0;
            end
            default: ;
        endcase
    end

    assign in_ready    = in_ready_q;
    assign s0_address  = s0_address_q;
    assign s0_we       = s0_we_q;
    assign s0_oe       = s0_oe_q;
    assign s0_din      = s0_din_q;
    assign s1_address  = s1_address_q;
    assign s1_we       = s1_we_q;
    assign s1_oe       = s1_oe_q;
    assign s1_din      = s1_din_q;
    assign core_req    = core_req_q;
    assign res_a       = res_a_q;
    assign res_b       = res_b_q;
    assign res_valid   = res_valid_q;
    assign busy        = busy_q;
    assign err_count   = err_count_q;
    assign err_timeout = err_timeout_q;
endmodule
